// File: rtl/jt89_wr_arb.sv
// Two-port write arbiter for the jt89 PSG: per-port byte FIFOs, ready-paced issue, tone latch/data atomicity.
// Optional JT89_WRARB_DROPCNT_EN adds saturating dropped-push counters drop0/drop1.
module jt89_wr_arb #(
    parameter int unsigned AW      = 2,
    parameter int unsigned WR_CYC  = 1,
    parameter int unsigned RDY_TO  = 4,
    parameter int unsigned LOCK_TO = 255
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_wr,
    input  logic [7:0] req0_din,
    output logic       req0_full,
    input  logic       req1_wr,
    input  logic [7:0] req1_din,
    output logic       req1_full,
    output logic       psg_wr_n,
    output logic       psg_ce_n,
    output logic [7:0] psg_din,
    input  logic       psg_ready,
    output logic       idle
`ifdef JT89_WRARB_DROPCNT_EN
    ,
    output logic [7:0] drop0,
    output logic [7:0] drop1
`endif
);
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CW    = 8;

    typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WLO, S_WHI} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [7:0]      din_d;
    logic            wr_n_d, idle_d;
    logic            rr, rr_d;
    logic            lock, lock_d, owner, owner_d, lock_hold;
    logic [7:0]      lcnt, lcnt_d;
    logic            gnt;
    logic [7:0]      gbyte;

    logic [7:0]      mem    [2][DEPTH];
    logic [AW-1:0]   wptr   [2];
    logic [AW-1:0]   rptr   [2];
    logic [AW:0]     fcnt   [2];
    logic [AW:0]     fcnt_d [2];
    logic [7:0]      req_din[2];
    logic [1:0]      req_wr, full_q, push, pop, elig;

    assign req_din[0] = req0_din;
    assign req_din[1] = req1_din;
    assign req_wr     = {req1_wr, req0_wr};
    assign push       = req_wr & ~full_q;
    assign req0_full  = full_q[0];
    assign req1_full  = full_q[1];

    function automatic logic is_latch(input logic [7:0] b);
        return b[7] & ~b[4] & (b[6:5] != 2'b11);
    endfunction

    always_comb begin
        for (int p = 0; p < 2; p++)
            fcnt_d[p] = fcnt[p] + (AW+1)'(push[p]) - (AW+1)'(pop[p]);
    end

    // FIFO storage carries no reset; only pointers and counts are cleared
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++)
            if (push[p]) mem[p][wptr[p]] <= req_din[p];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= '0;
            for (int p = 0; p < 2; p++) begin
                wptr[p] <= '0;
                rptr[p] <= '0;
                fcnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (push[p]) wptr[p] <= wptr[p] + AW'(1);
                if (pop[p])  rptr[p] <= rptr[p] + AW'(1);
                fcnt[p]   <= fcnt_d[p];
                full_q[p] <= (fcnt_d[p] == (AW+1)'(DEPTH));
            end
        end
    end

`ifdef JT89_WRARB_DROPCNT_EN
    logic [7:0] drop_q [2];
    assign drop0 = drop_q[0];
    assign drop1 = drop_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q[0] <= '0;
            drop_q[1] <= '0;
        end else begin
            for (int p = 0; p < 2; p++)
                if (req_wr[p] && full_q[p] && drop_q[p] != 8'hFF)
                    drop_q[p] <= drop_q[p] + 8'd1;
        end
    end
`endif

    // The lock stops holding in its final cycle so the other port can be granted as the count hits zero
    always_comb begin
        lock_hold = lock & (lcnt != 8'd1);
        elig[0]   = (fcnt[0] != '0) & (~lock_hold | ~owner);
        elig[1]   = (fcnt[1] != '0) & (~lock_hold |  owner);
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        din_d   = psg_din;
        rr_d    = rr;
        lock_d  = lock;
        owner_d = owner;
        lcnt_d  = lcnt;
        pop     = '0;
        gnt     = 1'b0;
        gbyte   = '0;

        if (lock) begin
            lcnt_d = lcnt - 8'd1;
            if (lcnt == 8'd1) lock_d = 1'b0;
        end

        case (state)
            S_IDLE: begin
                if (|elig) begin
                    gnt     = (&elig) ? rr : elig[1];
                    gbyte   = gnt ? mem[1][rptr[1]] : mem[0][rptr[0]];
                    pop     = gnt ? 2'b10 : 2'b01;
                    din_d   = gbyte;
                    cnt_d   = '0;
                    state_d = S_STROBE;
                    // rr names the favoured port; it only moves when both ports compete
                    if (&elig) rr_d = ~gnt;
                    if (is_latch(gbyte)) begin
                        lock_d  = 1'b1;
                        owner_d = gnt;
                        lcnt_d  = 8'(LOCK_TO);
                    end else if (lock && owner == gnt) begin
                        lock_d  = 1'b0;
                    end
                end
            end
            S_STROBE: begin
                if (cnt == CW'(WR_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_WLO;
                end else begin
                    cnt_d   = cnt + CW'(1);
                end
            end
            S_WLO: begin
                if (!psg_ready)                     state_d = S_WHI;
                else if (cnt == CW'(RDY_TO - 1))    state_d = S_IDLE;
                else                                cnt_d   = cnt + CW'(1);
            end
            S_WHI: begin
                if (psg_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        wr_n_d = (state_d != S_STROBE);
        idle_d = (fcnt_d[0] == '0) && (fcnt_d[1] == '0) && (state_d == S_IDLE) && !lock_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            psg_wr_n <= 1'b1;
            psg_ce_n <= 1'b1;
            psg_din  <= '0;
            rr       <= 1'b0;
            lock     <= 1'b0;
            owner    <= 1'b0;
            lcnt     <= '0;
            idle     <= 1'b1;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            psg_wr_n <= wr_n_d;
            psg_ce_n <= wr_n_d;
            psg_din  <= din_d;
            rr       <= rr_d;
            lock     <= lock_d;
            owner    <= owner_d;
            lcnt     <= lcnt_d;
            idle     <= idle_d;
        end
    end

endmodule

// File: tb/tb_jt89_wr_arb.sv
// Directed scoreboard bench for jt89_wr_arb: issue order, pacing, lock timing, FIFO overflow, reset.
module tb_jt89_wr_arb;
    localparam int unsigned AW      = 2;
    localparam int unsigned WR_CYC  = 1;
    localparam int unsigned RDY_TO  = 4;
    localparam int unsigned LOCK_TO = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_wr = 1'b0, req1_wr = 1'b0;
    logic [7:0] req0_din = '0, req1_din = '0;
    logic       req0_full, req1_full;
    logic       psg_wr_n, psg_ce_n, psg_ready, idle;
    logic [7:0] psg_din;
`ifdef JT89_WRARB_DROPCNT_EN
    logic [7:0] drop0, drop1;
`endif

    jt89_wr_arb #(.AW(AW), .WR_CYC(WR_CYC), .RDY_TO(RDY_TO), .LOCK_TO(LOCK_TO)) dut (
        .clk(clk), .rst(rst),
        .req0_wr(req0_wr), .req0_din(req0_din), .req0_full(req0_full),
        .req1_wr(req1_wr), .req1_din(req1_din), .req1_full(req1_full),
        .psg_wr_n(psg_wr_n), .psg_ce_n(psg_ce_n), .psg_din(psg_din),
        .psg_ready(psg_ready), .idle(idle)
`ifdef JT89_WRARB_DROPCNT_EN
        , .drop0(drop0), .drop1(drop1)
`endif
    );

    always #5 clk = ~clk;

    // ready source: 0 tied high, 1 jt89-like busy model, 2 held low
    int mode = 0;
    int busy = 0;
    always @(posedge clk) begin
        if (rst)            busy <= 0;
        else if (!psg_wr_n) busy <= 32;
        else if (busy != 0) busy <= busy - 1;
    end
    assign psg_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (busy == 0) : 1'b0;

    int         cmps = 0;
    int         errs = 0;
    int         cyc = 0;
    int         fall_prev = 0, fall_last = 0, low_w = 0;
    logic       prev_wr = 1'b1;
    logic [7:0] sb[$];
    logic [7:0] exp_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mon();
        if (rst) begin
            prev_wr = 1'b1;
            low_w   = 0;
            return;
        end
        if (!psg_wr_n) low_w++;
        if (!psg_wr_n && prev_wr) begin
            fall_prev = fall_last;
            fall_last = cyc;
            chk("ce_n_with_wr_n", 32'(psg_ce_n), 32'(0));
            if (mode == 1) chk("ready_at_strobe", 32'(psg_ready), 32'(1));
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 32'(sb.size()), 32'(1));
            end else begin
                exp_b = sb.pop_front();
                chk("psg_din_order", 32'(psg_din), 32'(exp_b));
            end
        end
        if (psg_wr_n && !prev_wr) begin
            chk("strobe_width", 32'(low_w), 32'(WR_CYC));
            low_w = 0;
        end
        prev_wr = psg_wr_n;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        mon();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input int n);
        int k = 0;
        while (!idle && k < n) begin
            tick();
            k++;
        end
        chk("wait_idle", 32'(idle), 32'(1));
    endtask

    initial begin
        // 1: reset values, two strobes from port 0 with no ready response
        do_reset();
        chk("rst_wr_n", 32'(psg_wr_n), 32'(1));
        chk("rst_ce_n", 32'(psg_ce_n), 32'(1));
        chk("rst_din",  32'(psg_din),  32'(0));
        chk("rst_full0", 32'(req0_full), 32'(0));
        chk("rst_full1", 32'(req1_full), 32'(0));
        chk("rst_idle", 32'(idle), 32'(1));
        mode = 0;
        sb.push_back(8'h9F); sb.push_back(8'hBF);
        req0_wr = 1'b1; req0_din = 8'h9F; tick();
        req0_din = 8'hBF; tick();
        req0_wr = 1'b0;
        wait_idle(100);
        chk("t1_spacing", 32'(fall_last - fall_prev), 32'(WR_CYC + RDY_TO + 1));
        chk("t1_din_hold", 32'(psg_din), 32'(8'hBF));
        chk("t1_sb_empty", 32'(sb.size()), 32'(0));

        // 2: simultaneous volume writes, round robin across two rounds
        do_reset();
        sb.push_back(8'h90); sb.push_back(8'hB0);
        req0_wr = 1'b1; req0_din = 8'h90; req1_wr = 1'b1; req1_din = 8'hB0; tick();
        req0_wr = 1'b0; req1_wr = 1'b0;
        wait_idle(100);
        sb.push_back(8'hB1); sb.push_back(8'h91);
        req0_wr = 1'b1; req0_din = 8'h91; req1_wr = 1'b1; req1_din = 8'hB1; tick();
        req0_wr = 1'b0; req1_wr = 1'b0;
        wait_idle(100);
        chk("t2_sb_empty", 32'(sb.size()), 32'(0));

        // 3: port 0 tone latch holds the bus until its data byte arrives
        do_reset();
        sb.push_back(8'h8A); sb.push_back(8'h3F); sb.push_back(8'hC5); sb.push_back(8'h12);
        req0_wr = 1'b1; req0_din = 8'h8A; req1_wr = 1'b1; req1_din = 8'hC5; tick();
        req0_wr = 1'b0; req1_din = 8'h12; tick();
        req1_wr = 1'b0;
        repeat (9) tick();
        req0_wr = 1'b1; req0_din = 8'h3F; tick();
        req0_wr = 1'b0;
        wait_idle(500);
        chk("t3_sb_empty", 32'(sb.size()), 32'(0));

        // 4: orphan latch expires after exactly LOCK_TO cycles
        do_reset();
        sb.push_back(8'h8A); sb.push_back(8'hF0);
        req0_wr = 1'b1; req0_din = 8'h8A; req1_wr = 1'b1; req1_din = 8'hF0; tick();
        req0_wr = 1'b0; req1_wr = 1'b0;
        wait_idle(600);
        chk("t4_lock_delay", 32'(fall_last - fall_prev), 32'(LOCK_TO));
        chk("t4_sb_empty", 32'(sb.size()), 32'(0));

        // 5: jt89-like ready, stream of bytes from port 0
        do_reset();
        mode = 1;
        begin
            logic [7:0] seq [5];
            seq[0] = 8'h90; seq[1] = 8'h01; seq[2] = 8'hA5; seq[3] = 8'h02; seq[4] = 8'hE3;
            for (int i = 0; i < 5; i++) begin
                sb.push_back(seq[i]);
                req0_wr = 1'b1; req0_din = seq[i]; tick();
            end
            req0_wr = 1'b0;
        end
        wait_idle(1000);
        chk("t5_sb_empty", 32'(sb.size()), 32'(0));
        chk("t5_full0", 32'(req0_full), 32'(0));

        // 6: overflow port 1 while the PSG is stuck busy
        do_reset();
        mode = 2;
        sb.push_back(8'h9F);
        req0_wr = 1'b1; req0_din = 8'h9F; tick();
        req0_wr = 1'b0;
        repeat (10) tick();
        for (int i = 1; i <= 7; i++) begin
            if (i <= 4) sb.push_back(8'(i));
            req1_wr = 1'b1; req1_din = 8'(i); tick();
        end
        req1_wr = 1'b0;
        tick();
        chk("t6_full1", 32'(req1_full), 32'(1));
        chk("t6_idle_busy", 32'(idle), 32'(0));
`ifdef JT89_WRARB_DROPCNT_EN
        chk("t6_drop1", 32'(drop1), 32'(3));
        chk("t6_drop0", 32'(drop0), 32'(0));
`endif
        mode = 0;
        wait_idle(200);
        chk("t6_full1_drained", 32'(req1_full), 32'(0));
        chk("t6_sb_empty", 32'(sb.size()), 32'(0));

        // reset mid-strobe discards the queued byte
        sb.push_back(8'h5A);
        req0_wr = 1'b1; req0_din = 8'h5A; tick();
        req0_din = 8'h5B; tick();
        req0_wr = 1'b0;
        for (int k = 0; k < 20 && psg_wr_n; k++) tick();
        chk("t6_strobe_low", 32'(psg_wr_n), 32'(0));
        rst = 1'b1; tick();
        chk("t6_rst_wr_n", 32'(psg_wr_n), 32'(1));
        chk("t6_rst_ce_n", 32'(psg_ce_n), 32'(1));
        rst = 1'b0;
        repeat (20) tick();
        chk("t6_rst_idle", 32'(idle), 32'(1));
        chk("t6_rst_sb_empty", 32'(sb.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
